// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with valid/ready handshake and a 2-entry skid buffer.
// MEM back-pressure never drops a beat. Flush empties the stage. A saturating counter records MEM stalls.
module ex_mem_skid_stage #(
  parameter int               DATA_W     = 16,
  parameter int               OPC_W      = 4,
  parameter int               REG_W      = 3,
  parameter logic [OPC_W-1:0] NOP_OPCODE = '0,
  parameter int               CNT_W      = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic              in_zero,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_W-1:0]  in_dest_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPC_W-1:0]  out_opcode,
  output logic              out_zero,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_dest_reg,
  output logic [CNT_W-1:0]  stall_cycles
);

  // state | meaning
  // EMPTY | no beat held, outputs show a bubble
  // ONE   | MAIN holds the beat presented to MEM
  // FULL  | MAIN presented, SKID holds the next beat, input blocked
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic              zero;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  dest_reg;
  } beat_t;

  state_t           state;
  beat_t            main_q;
  beat_t            skid_q;
  beat_t            in_beat;
  logic             in_ready_q;
  logic [CNT_W-1:0] stall_q;
  logic             accept;
  logic             pop;

  assign in_beat = '{opcode: in_opcode, zero: in_zero, result: in_result,
                     store_data: in_store_data, dest_reg: in_dest_reg};

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
      stall_q    <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + 1'b1;

      // A pop in the flush cycle has already been seen by MEM, so dropping everything is safe.
      if (flush) begin
        state      <= EMPTY;
        in_ready_q <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              main_q <= in_beat;
              state  <= ONE;
            end
          end
          ONE: begin
            if (accept && pop) begin
              main_q <= in_beat;
            end else if (accept) begin
              skid_q     <= in_beat;
              state      <= FULL;
              in_ready_q <= 1'b0;
            end else if (pop) begin
              state <= EMPTY;
            end
          end
          FULL: begin
            if (pop) begin
              main_q     <= skid_q;
              state      <= ONE;
              in_ready_q <= 1'b1;
            end
          end
          default: begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign out_opcode     = out_valid ? main_q.opcode     : NOP_OPCODE;
  assign out_zero       = out_valid ? main_q.zero       : 1'b0;
  assign out_result     = out_valid ? main_q.result     : '0;
  assign out_store_data = out_valid ? main_q.store_data : '0;
  assign out_dest_reg   = out_valid ? main_q.dest_reg   : '0;
  assign stall_cycles   = stall_q;

endmodule
